// File: rtl/ila_pkg.sv
// Shared types and constants for the UART-controlled logic analyzer.
package ila_pkg;

  localparam int SAMPLE_W = 3;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] LF        = 8'h0A;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DUMP} state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [1:0] {DS_FETCH, DS_SEND, DS_HOLD, DS_WAIT} dump_step_t;

  function automatic logic [7:0] sample_char(input logic [SAMPLE_W-1:0] s);
    return CHAR_ZERO + 8'(s);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: takes a byte when idle, holds busy until the stop bit ends.
module uart_tx #(
  parameter int unsigned CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       busy,
  output logic       txd
);

  localparam int BW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [BW-1:0] LAST_BAUD = BW'(CLOCKS_PER_BAUD - 1);

  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shift;

  // bit_idx counts bit periods already on the line: 0 is the start bit, 9 the stop bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '1;
    end else if (!busy) begin
      if (valid) begin
        busy     <= 1'b1;
        txd      <= 1'b0;
        shift    <= {1'b1, data};
        baud_cnt <= '0;
        bit_idx  <= '0;
      end
    end else if (baud_cnt == LAST_BAUD) begin
      baud_cnt <= '0;
      if (bit_idx == 4'd9) begin
        busy <= 1'b0;
        txd  <= 1'b1;
      end else begin
        txd     <= shift[0];
        shift   <= {1'b1, shift[8:1]};
        bit_idx <= bit_idx + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_ila.sv
// Three-probe logic analyzer: armed over UART, captures FIFO_DEPTH samples, dumps them as ASCII.
module uart_ila
  import ila_pkg::*;
#(
  parameter int unsigned         FIFO_DEPTH      = 64,
  parameter int unsigned         CLOCKS_PER_BAUD = 868,
  parameter logic [SAMPLE_W-1:0] TRIGGER_MASK    = 3'b111,
  parameter logic [SAMPLE_W-1:0] TRIGGER_VALUE   = 3'b000,
  parameter logic [7:0]          ARM_BYTE        = 8'h30
) (
  input  logic clk,
  input  logic rst,
  input  logic probe0,
  input  logic probe1,
  input  logic probe2,
  input  logic rxd,
  output logic txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [BW-1:0] LAST_BAUD = BW'(CLOCKS_PER_BAUD - 1);
  localparam logic [BW-1:0] HALF_BAUD = BW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CR_INDEX  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LF_INDEX  = CW'(FIFO_DEPTH + 1);

  logic [SAMPLE_W-1:0] sample;
  logic                trig_hit;

  assign sample   = {probe2, probe1, probe0};
  assign trig_hit = ((sample & TRIGGER_MASK) == (TRIGGER_VALUE & TRIGGER_MASK));

  logic rx_meta, rx_sync, rx_prev;

  // rxd is asynchronous; the third flop only serves start-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t     rx_state;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_data;
  logic          rx_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_BAUD) begin
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == LAST_BAUD) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bits  <= rx_bits + 3'd1;
            if (rx_bits == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == LAST_BAUD) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_shift;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  state_t              state;
  dump_step_t          step;
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [CW-1:0]       char_cnt;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [SAMPLE_W-1:0] rd_data;
  logic [7:0]          next_char;

  assign wr_en   = ((state == ARMED) && trig_hit) || (state == CAPTURE);
  assign wr_addr = (state == CAPTURE) ? wptr : '0;

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= sample;
    rd_data <= mem[rptr];
  end

  assign next_char = (char_cnt < CR_INDEX)  ? sample_char(rd_data) :
                     (char_cnt == CR_INDEX) ? CR : LF;

  // DS_FETCH covers the RAM read latency; DS_HOLD lets TX register the byte before busy is polled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      step     <= DS_FETCH;
      wptr     <= '0;
      rptr     <= '0;
      char_cnt <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == ARM_BYTE)) state <= ARMED;
        end
        ARMED: begin
          if (trig_hit) begin
            state <= CAPTURE;
            wptr  <= AW'(1);
          end
        end
        CAPTURE: begin
          wptr <= wptr + 1'b1;
          if (wptr == LAST_ADDR) begin
            state    <= DUMP;
            step     <= DS_FETCH;
            rptr     <= '0;
            char_cnt <= '0;
          end
        end
        DUMP: begin
          case (step)
            DS_FETCH: step <= DS_SEND;
            DS_SEND: begin
              if (!tx_busy) begin
                tx_data  <= next_char;
                tx_valid <= 1'b1;
                step     <= DS_HOLD;
              end
            end
            DS_HOLD: begin
              tx_valid <= 1'b0;
              step     <= DS_WAIT;
            end
            DS_WAIT: begin
              if (!tx_busy) begin
                if (char_cnt == LF_INDEX) begin
                  state <= IDLE;
                end else begin
                  char_cnt <= char_cnt + 1'b1;
                  rptr     <= rptr + 1'b1;
                end
                step <= DS_FETCH;
              end
            end
            default: step <= DS_FETCH;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (tx_data),
    .valid(tx_valid),
    .busy (tx_busy),
    .txd  (txd)
  );

endmodule

// File: tb/tb_uart_ila.sv
// Randomized self-checking bench for uart_ila with a shortened baud period.
module tb_uart_ila;

  localparam int DEPTH  = 64;
  localparam int CPB    = 8;
  localparam int FRAMES = DEPTH + 2;
  localparam int DUMP_BUDGET = FRAMES * 10 * CPB + 1000;

  localparam int M_HOLD    = 0;
  localparam int M_COUNT   = 1;
  localparam int M_NONZERO = 2;
  localparam int M_PLAY    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [2:0] probe_bus = 3'b111;
  logic       txd;

  int checks = 0;
  int passed = 0;

  int         mode = M_HOLD;
  logic [2:0] hold_val = 3'b111;
  logic [2:0] cnt3 = 3'b000;
  logic [2:0] play_q[$];
  logic [2:0] cap_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  int         frame_err = 0;

  uart_ila #(
    .FIFO_DEPTH     (DEPTH),
    .CLOCKS_PER_BAUD(CPB),
    .TRIGGER_MASK   (3'b111),
    .TRIGGER_VALUE  (3'b000),
    .ARM_BYTE       (8'h30)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .probe0(probe_bus[0]),
    .probe1(probe_bus[1]),
    .probe2(probe_bus[2]),
    .rxd   (rxd),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  // Probe source, updated away from the sampling edge
  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        M_COUNT: begin
          probe_bus = cnt3;
          cnt3 = cnt3 + 3'd1;
        end
        M_NONZERO: probe_bus = 3'($urandom_range(1, 7));
        M_PLAY: begin
          if (play_q.size() > 0) begin
            probe_bus = play_q.pop_front();
          end else begin
            mode = M_HOLD;
            probe_bus = hold_val;
          end
        end
        default: probe_bus = hold_val;
      endcase
    end
  end

  // Host-side UART receiver collecting every frame the DUT emits
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge txd);
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1;
          b[i] = txd;
        end
        repeat (CPB) @(posedge clk);
        #1;
        if (txd !== 1'b1) frame_err++;
        tx_q.push_back(b);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d frames", tx_q.size());
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic idle_window(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
  endtask

  // Reference: each captured sample becomes ASCII '0'+value, followed by CR LF
  task automatic build_expected();
    exp_q.delete();
    foreach (cap_q[i]) exp_q.push_back(8'h30 + {5'b00000, cap_q[i]});
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic counter_model();
    cap_q.delete();
    for (int i = 0; i < DEPTH; i++) cap_q.push_back(3'(i % 8));
    build_expected();
  endtask

  task automatic start_playback();
    logic [2:0] seq[$];
    seq.push_back(3'b000);
    for (int i = 1; i < DEPTH; i++) seq.push_back(3'($urandom_range(0, 7)));
    cap_q = seq;
    build_expected();
    hold_val = 3'b000;
    @(posedge clk);
    #1;
    play_q = seq;
    mode = M_PLAY;
  endtask

  task automatic test_reset();
    int lows;
    rst = 1'b0;
    rxd = 1'b1;
    mode = M_HOLD;
    hold_val = 3'b000;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1) $display("[TB] FAIL reset_txd: got %b expected 1", txd);
    else passed++;
    rst = 1'b1;
    idle_window(100, lows);
    checks++;
    if (lows !== 0) $display("[TB] FAIL reset_idle_txd: got %0d low cycles expected 0", lows);
    else passed++;
    checks++;
    if (tx_q.size() !== 0) $display("[TB] FAIL reset_no_frames: got %0d frames expected 0", tx_q.size());
    else passed++;
  endtask

  task automatic test_counter();
    bit ok;
    tx_q.delete();
    frame_err = 0;
    mode = M_COUNT;
    counter_model();
    send_byte(8'h30, 1'b1);
    wait_bytes(FRAMES, DUMP_BUDGET, ok);
    checks++;
    if (!ok) $display("[TB] FAIL counter_dump_done: got %0d frames expected %0d", tx_q.size(), FRAMES);
    else passed++;
    repeat (30 * CPB) @(posedge clk);
    checks++;
    if (tx_q.size() !== FRAMES) $display("[TB] FAIL counter_frame_count: got %0d expected %0d", tx_q.size(), FRAMES);
    else passed++;
    for (int i = 0; i < FRAMES; i++) begin
      checks++;
      if (tx_q[i] !== exp_q[i]) $display("[TB] FAIL counter_byte[%0d]: got %h expected %h", i, tx_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (frame_err !== 0) $display("[TB] FAIL counter_stop_bits: got %0d bad stop bits expected 0", frame_err);
    else passed++;
  endtask

  task automatic test_ignored_bytes();
    int lows;
    int lows2;
    logic [7:0] junk;
    tx_q.delete();
    mode = M_HOLD;
    hold_val = 3'b000;
    junk = 8'($urandom_range(0, 255));
    if (junk == 8'h30) junk = 8'h5A;
    send_byte(8'h31, 1'b1);
    send_byte(8'h30, 1'b0);
    send_byte(junk, 1'b1);
    idle_window(40 * CPB, lows);
    checks++;
    if (tx_q.size() !== 0) $display("[TB] FAIL ignored_no_frames: got %0d frames expected 0", tx_q.size());
    else passed++;
    checks++;
    if (lows !== 0) $display("[TB] FAIL ignored_txd_idle: got %0d low cycles expected 0", lows);
    else passed++;
    // A real arm afterwards must still work, proving the receiver recovered
    counter_model();
    mode = M_COUNT;
    send_byte(8'h30, 1'b1);
    idle_window(20 * CPB, lows2);
    checks++;
    if (lows2 === 0) $display("[TB] FAIL ignored_rearm: got no TX activity expected a dump");
    else passed++;
    begin
      bit ok;
      wait_bytes(FRAMES, DUMP_BUDGET, ok);
    end
    repeat (30 * CPB) @(posedge clk);
  endtask

  task automatic test_random_trigger(input int iterations);
    bit ok;
    for (int it = 0; it < iterations; it++) begin
      tx_q.delete();
      frame_err = 0;
      mode = M_NONZERO;
      send_byte(8'h30, 1'b1);
      repeat ($urandom_range(20, 200)) @(posedge clk);
      start_playback();
      wait_bytes(FRAMES, DUMP_BUDGET, ok);
      checks++;
      if (!ok) $display("[TB] FAIL random_dump_done[%0d]: got %0d frames expected %0d", it, tx_q.size(), FRAMES);
      else passed++;
      repeat (30 * CPB) @(posedge clk);
      checks++;
      if (tx_q.size() !== FRAMES) $display("[TB] FAIL random_frame_count[%0d]: got %0d expected %0d", it, tx_q.size(), FRAMES);
      else passed++;
      for (int i = 0; i < FRAMES; i++) begin
        checks++;
        if (tx_q[i] !== exp_q[i]) $display("[TB] FAIL random_byte[%0d][%0d]: got %h expected %h", it, i, tx_q[i], exp_q[i]);
        else passed++;
      end
      checks++;
      if (frame_err !== 0) $display("[TB] FAIL random_stop_bits[%0d]: got %0d expected 0", it, frame_err);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    tx_q.delete();
    mode = M_NONZERO;
    send_byte(8'h30, 1'b1);
    repeat (50) @(posedge clk);
    start_playback();
    wait_bytes(5, DUMP_BUDGET, ok);
    checks++;
    if (!ok) $display("[TB] FAIL b2b_dump_started: got %0d frames expected at least 5", tx_q.size());
    else passed++;
    send_byte(8'h30, 1'b1);
    wait_bytes(FRAMES, DUMP_BUDGET, ok);
    repeat (200 * CPB) @(posedge clk);
    checks++;
    if (tx_q.size() !== FRAMES) $display("[TB] FAIL b2b_frame_count: got %0d expected %0d", tx_q.size(), FRAMES);
    else passed++;
    for (int i = 0; i < FRAMES; i++) begin
      checks++;
      if (tx_q[i] !== exp_q[i]) $display("[TB] FAIL b2b_byte[%0d]: got %h expected %h", i, tx_q[i], exp_q[i]);
      else passed++;
    end
    tx_q.delete();
    counter_model();
    mode = M_COUNT;
    send_byte(8'h30, 1'b1);
    wait_bytes(FRAMES, DUMP_BUDGET, ok);
    repeat (30 * CPB) @(posedge clk);
    checks++;
    if (tx_q.size() !== FRAMES) $display("[TB] FAIL b2b_rearm_count: got %0d expected %0d", tx_q.size(), FRAMES);
    else passed++;
    for (int i = 0; i < FRAMES; i++) begin
      checks++;
      if (tx_q[i] !== exp_q[i]) $display("[TB] FAIL b2b_rearm_byte[%0d]: got %h expected %h", i, tx_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_stuck_probes();
    bit ok;
    int lows;
    tx_q.delete();
    mode = M_HOLD;
    hold_val = 3'b101;
    send_byte(8'h30, 1'b1);
    idle_window(1000, lows);
    checks++;
    if ((tx_q.size() !== 0) || (lows !== 0))
      $display("[TB] FAIL stuck_no_trigger: got %0d frames and %0d low cycles expected 0 and 0", tx_q.size(), lows);
    else passed++;
    start_playback();
    wait_bytes(FRAMES, DUMP_BUDGET, ok);
    repeat (30 * CPB) @(posedge clk);
    checks++;
    if (tx_q.size() !== FRAMES) $display("[TB] FAIL stuck_frame_count: got %0d expected %0d", tx_q.size(), FRAMES);
    else passed++;
    checks++;
    if (tx_q[0] !== 8'h30) $display("[TB] FAIL stuck_first_char: got %h expected 30", tx_q[0]);
    else passed++;
    for (int i = 1; i < FRAMES; i++) begin
      checks++;
      if (tx_q[i] !== exp_q[i]) $display("[TB] FAIL stuck_byte[%0d]: got %h expected %h", i, tx_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_dump();
    bit ok;
    bit low_found;
    int lows;
    tx_q.delete();
    mode = M_COUNT;
    send_byte(8'h30, 1'b1);
    wait_bytes(5, DUMP_BUDGET, ok);
    low_found = 1'b0;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        low_found = 1'b1;
        break;
      end
    end
    checks++;
    if (!(ok && low_found)) $display("[TB] FAIL midreset_setup: got frames=%0d low_found=%b expected a frame in flight", tx_q.size(), low_found);
    else passed++;
    mode = M_HOLD;
    hold_val = 3'b000;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1) $display("[TB] FAIL midreset_txd_immediate: got %b expected 1", txd);
    else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    tx_q.delete();
    idle_window(2000, lows);
    checks++;
    if ((tx_q.size() !== 0) || (lows !== 0))
      $display("[TB] FAIL midreset_quiet: got %0d frames and %0d low cycles expected 0 and 0", tx_q.size(), lows);
    else passed++;
    counter_model();
    mode = M_COUNT;
    send_byte(8'h30, 1'b1);
    wait_bytes(FRAMES, DUMP_BUDGET, ok);
    repeat (30 * CPB) @(posedge clk);
    checks++;
    if (tx_q.size() !== FRAMES) $display("[TB] FAIL midreset_rearm_count: got %0d expected %0d", tx_q.size(), FRAMES);
    else passed++;
    for (int i = 0; i < FRAMES; i++) begin
      checks++;
      if (tx_q[i] !== exp_q[i]) $display("[TB] FAIL midreset_rearm_byte[%0d]: got %h expected %h", i, tx_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_ignored_bytes();
    test_random_trigger(2);
    test_back_to_back();
    test_stuck_probes();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
